reg_demux1x4: RTL and testbench



---
 rtl/reg_demux1x4.sv | 110 +++++++++++
 tb/tb_reg_demux1x4.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_demux1x4.sv
// Registered 1-to-4 demultiplexer: one producer stream steered by sel into four
// independent one-entry output buffers, each drained by its own consumer.

module reg_demux1x4_lane #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i_data,
  input  logic             i_load,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [width-1:0] o_data,
  output logic             o_valid
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [width-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Flush wins over both drain and load; drain+load keeps the entry full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (i_load && !i_flush) w_state_nxt = FULL;
      FULL: begin
        if (i_flush)                 w_state_nxt = EMPTY;
        else if (!i_load && i_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Data only moves on an accepted load; it is held through drain and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_data <= '0;
    else if (i_load && !i_flush) r_data <= i_data;
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == FULL);

endmodule

module reg_demux1x4 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [width-1:0] out0,
  output logic [width-1:0] out1,
  output logic [width-1:0] out2,
  output logic [width-1:0] out3,
  output logic             valid0,
  output logic             valid1,
  output logic             valid2,
  output logic             valid3,
  input  logic             ready0,
  input  logic             ready1,
  input  logic             ready2,
  input  logic             ready3,
  output logic             busy
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            w_ready;
  logic [NUM_LANES-1:0]            w_valid;
  logic [NUM_LANES-1:0]            w_load;
  logic [NUM_LANES-1:0][width-1:0] w_data;
  logic                            w_accept;

  assign w_ready = {ready3, ready2, ready1, ready0};

  // Ready looks only at the selected lane, so a stalled lane never blocks others.
  assign in_ready = !flush && (!w_valid[sel] || w_ready[sel]);
  assign w_accept = in_valid && in_ready;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_load[g] = w_accept && (sel == 2'(g));

    reg_demux1x4_lane #(.width(width)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (in),
      .i_load  (w_load[g]),
      .i_ready (w_ready[g]),
      .i_flush (flush),
      .o_data  (w_data[g]),
      .o_valid (w_valid[g])
    );
  end

  assign {out3, out2, out1, out0}         = w_data;
  assign {valid3, valid2, valid1, valid0} = w_valid;
  assign busy                             = |w_valid;

endmodule

// File: tb/tb_reg_demux1x4.sv
// Self-checking bench for reg_demux1x4: table vectors plus hand sequences,
// with a per-output scoreboard queue filled on accept and drained on consume.

module tb_reg_demux1x4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] sel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic       valid0, valid1, valid2, valid3;
  logic [3:0] rdy = '0;
  logic       busy;

  logic [3:0][7:0] outs;
  logic [3:0]      valids;
  assign outs   = {out3, out2, out1, out0};
  assign valids = {valid3, valid2, valid1, valid0};

  reg_demux1x4 #(.width(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ready0(rdy[0]), .ready1(rdy[1]), .ready2(rdy[2]), .ready3(rdy[3]),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb [4][$];
  logic [7:0] m_out [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drives one cycle starting just after a rising edge; returns the sampled in_ready.
  task automatic step(input logic [7:0] d, input logic [1:0] s, input logic iv,
                      input logic fl, input logic [3:0] r, output logic got_rdy);
    logic       er;
    logic [7:0] pv;
    din = d; sel = s; in_valid = iv; flush = fl; rdy = r;
    #1;
    got_rdy = in_ready;
    er = !fl && (sb[s].size() == 0 || r[s]);
    chk("in_ready", in_ready, er);
    for (int k = 0; k < 4; k++) begin
      if (fl) sb[k].delete();
      else if (sb[k].size() != 0 && r[k]) begin
        pv = sb[k].pop_front();
        chk($sformatf("drain_out%0d", k), outs[k], pv);
      end
    end
    if (iv && er) begin
      sb[s].push_back(d);
      m_out[s] = d;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), valids[k], sb[k].size() != 0);
      chk($sformatf("out%0d", k), outs[k], m_out[k]);
    end
    chk("busy", busy, (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
    logic       iv;
    logic       fl;
    logic [3:0] r;
    logic       e_rdy;
    logic [3:0] e_vld;
  } vec_t;

  vec_t vt [10];
  logic gr;

  initial begin
    // steer, hold under back-pressure for 5 cycles, then drain+load, then drain
    vt[0] = '{8'hA5, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0100};
    vt[1] = '{8'h11, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100};
    vt[2] = '{8'h22, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100};
    for (int i = 3; i < 8; i++)
      vt[i] = '{8'h3C, 2'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100};
    vt[8] = '{8'h3C, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100};
    vt[9] = '{8'h00, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000};

    for (int k = 0; k < 4; k++) m_out[k] = 8'h00;

    // reset state, in_ready tracks !flush only
    #2;
    chk("rst_valids", valids, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    flush = 1'b1; #1;
    chk("rst_in_ready_flush", in_ready, 1'b0);
    flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // asynchronous reset mid-cycle with valid1 set
    step(8'h5A, 2'd1, 1'b1, 1'b0, 4'b0000, gr);
    #2; rst_n = 1'b0; #1;
    chk("async_rst_valids", valids, 4'b0000);
    chk("async_rst_outs", outs, 32'h0);
    chk("async_rst_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin sb[k].delete(); m_out[k] = 8'h00; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      step(vt[i].d, vt[i].s, vt[i].iv, vt[i].fl, vt[i].r, gr);
      chk($sformatf("vec%0d_in_ready", i), gr, vt[i].e_rdy);
      chk($sformatf("vec%0d_valids", i), valids, vt[i].e_vld);
    end

    // streaming 16 back-to-back transfers into output 0
    for (int i = 0; i < 16; i++) begin
      step(8'(i), 2'd0, 1'b1, 1'b0, 4'b0001, gr);
      chk("stream_in_ready", gr, 1'b1);
      chk("stream_out0", out0, 8'(i));
    end
    step(8'h00, 2'd0, 1'b0, 1'b0, 4'b0001, gr);
    chk("stream_end_valid0", valid0, 1'b0);

    // flush beats a simultaneous accept and drain
    step(8'h77, 2'd0, 1'b1, 1'b0, 4'b0000, gr);
    step(8'h88, 2'd3, 1'b1, 1'b0, 4'b0000, gr);
    step(8'h99, 2'd1, 1'b1, 1'b1, 4'b1000, gr);
    chk("flush_in_ready", gr, 1'b0);
    chk("flush_valids", valids, 4'b0000);
    chk("flush_busy", busy, 1'b0);
    chk("flush_out1_kept", out1, 8'h00);
    chk("flush_out3_kept", out3, 8'h88);

    // output 1 stalled while 0, 2, 3 accept in consecutive cycles
    step(8'h44, 2'd1, 1'b1, 1'b0, 4'b0000, gr);
    step(8'h10, 2'd0, 1'b1, 1'b0, 4'b0000, gr);
    step(8'h20, 2'd2, 1'b1, 1'b0, 4'b0000, gr);
    step(8'h30, 2'd3, 1'b1, 1'b0, 4'b0000, gr);
    chk("indep_valids", valids, 4'b1111);
    chk("indep_out1", out1, 8'h44);
    step(8'h55, 2'd1, 1'b1, 1'b0, 4'b1101, gr);
    chk("indep_stalled_in_ready", gr, 1'b0);
    chk("indep_out1_held", out1, 8'h44);
    step(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, gr);
    chk("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
